// File: rtl/fifo_read_ctrl_if.sv
// rtl/fifo_read_ctrl_if.sv - consumer-side first-word-fall-through handshake of the FIFO read controller
//
// Signals:
//   dout        head-of-buffer data
//   dout_valid  dout holds a valid word
//   dout_ready  consumer accepts the head word this cycle
// Modports:
//   master  the read controller (drives dout/dout_valid)
//   slave   the consumer (drives dout_ready)
interface fifo_read_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-domain controller for the async FIFO
//
// Owns the read pointer, decodes the synchronized Gray write pointer, issues
// synchronous RAM reads and serves a 2-entry first-word-fall-through buffer.
//
// Ports:
//   read_clk         read-domain clock (posedge)
//   rst              synchronous active-high reset
//   synch_write_ptr  Gray write pointer already synchronized into read_clk
//   mem_rd_en        RAM read strobe
//   mem_rd_addr      RAM read address
//   mem_rd_data      RAM data, valid the cycle after mem_rd_en
//   read_ptr_gray    registered Gray read pointer for the write domain
//   rd_if            consumer handshake (dout / dout_valid / dout_ready)
//   empty            no word presented to the consumer
//   almost_empty     registered, rd_level <= AE_THRESH
//   rd_level         registered count of unread words (RAM + buffered + in flight)
//   underflow        sticky, dout_ready seen while empty (FIFO_RD_UNDERFLOW_FLAG_EN only)
//   underflow_cnt    saturating count of those events (FIFO_RD_UNDERFLOW_FLAG_EN only)
//
// Optional feature macro: FIFO_RD_UNDERFLOW_FLAG_EN
module fifo_read_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int AE_THRESH = 1
) (
  input  logic              read_clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   synch_write_ptr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W:0]   read_ptr_gray,
  fifo_read_ctrl_if.master  rd_if,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W+1:0] rd_level
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
  ,
  output logic              underflow,
  output logic [7:0]        underflow_cnt
`endif
);

  localparam logic [ADDR_W+1:0] AE_LVL = AE_THRESH[ADDR_W+1:0];

  logic [ADDR_W:0]   rd_ptr_bin;
  logic [ADDR_W:0]   rd_ptr_inc;
  logic [ADDR_W:0]   wr_bin;
  logic [ADDR_W:0]   mem_avail;
  logic              mem_empty;

  logic [1:0]        held;
  logic [1:0]        held_after_pop;
  logic [1:0]        held_next;
  logic              inflight;
  logic              dout_valid;
  logic              pop;
  logic [2:0]        occ;

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] head_next;
  logic [DATA_W-1:0] skid_next;

  logic [ADDR_W+1:0] rd_level_next;

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wr_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wr_bin[i] = ^(synch_write_ptr >> i);
    end
  end

  assign mem_avail = wr_bin - rd_ptr_bin;
  assign mem_empty = (mem_avail == '0);

  assign dout_valid = (held != 2'd0);
  assign pop        = dout_valid & rd_if.dout_ready;

  // Slots committed after this edge: buffered words plus the one returning
  // from RAM, minus the one leaving. A new read is only issued if it will
  // find a free slot when its data returns.
  assign occ       = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
  assign mem_rd_en = !rst & !mem_empty & (occ < 3'd2);

  assign mem_rd_addr = rd_ptr_bin[ADDR_W-1:0];
  assign rd_ptr_inc  = rd_ptr_bin + (ADDR_W+1)'(1);

  // Buffer next state: pop shifts skid into head, then returning data lands
  // in the first free slot after the pop.
  always_comb begin
    held_after_pop = held - {1'b0, pop};
    head_next      = head;
    skid_next      = skid;
    if (pop) begin
      head_next = skid;
    end
    if (inflight) begin
      if (held_after_pop == 2'd0) begin
        head_next = mem_rd_data;
      end else begin
        skid_next = mem_rd_data;
      end
    end
    held_next = held_after_pop + {1'b0, inflight};
  end

  // The issue decrements mem_avail and sets inflight by the same amount, so
  // the unread total reduces to current mem_avail plus next buffer fill.
  assign rd_level_next = {1'b0, mem_avail} + {{ADDR_W{1'b0}}, held_next};

  always_ff @(posedge read_clk) begin
    if (rst) begin
      rd_ptr_bin    <= '0;
      read_ptr_gray <= '0;
      inflight      <= 1'b0;
      held          <= 2'd0;
      head          <= '0;
      skid          <= '0;
      rd_level      <= '0;
      almost_empty  <= 1'b1;
    end else begin
      if (mem_rd_en) begin
        rd_ptr_bin    <= rd_ptr_inc;
        read_ptr_gray <= rd_ptr_inc ^ (rd_ptr_inc >> 1);
      end
      inflight     <= mem_rd_en;
      held         <= held_next;
      head         <= head_next;
      skid         <= skid_next;
      rd_level     <= rd_level_next;
      almost_empty <= (rd_level_next <= AE_LVL);
      assert (!(inflight && (held_after_pop == 2'd2)));
    end
  end

  assign rd_if.dout       = head;
  assign rd_if.dout_valid = dout_valid;
  assign empty            = !dout_valid;

`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
  logic uf_event;
  assign uf_event = rd_if.dout_ready & !dout_valid;

  always_ff @(posedge read_clk) begin
    if (rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= 8'd0;
    end else begin
      if (uf_event) begin
        underflow <= 1'b1;
        if (underflow_cnt != 8'hFF) begin
          underflow_cnt <= underflow_cnt + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - randomized self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int AE_THRESH = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W:0]   synch_write_ptr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [ADDR_W:0]   read_ptr_gray;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W+1:0] rd_level;
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
  logic              underflow;
  logic [7:0]        underflow_cnt;
`endif

  fifo_read_ctrl_if #(.DATA_W(DATA_W)) rd_if ();

  fifo_read_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AE_THRESH(AE_THRESH)
  ) dut (
    .read_clk(clk),
    .rst(rst),
    .synch_write_ptr(synch_write_ptr),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .read_ptr_gray(read_ptr_gray),
    .rd_if(rd_if),
    .empty(empty),
    .almost_empty(almost_empty),
    .rd_level(rd_level)
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
    ,
    .underflow(underflow),
    .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port RAM read port: registered read.
  logic [DATA_W-1:0] ram [8];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: words written, reads issued, words popped.
  int               wr_cnt;
  int               issues;
  int               pops;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W:0]  prev_gray;
  bit               uf_m;
  int               uf_cnt_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W:0] to_gray(input int n);
    int m;
    m = n % 16;
    m = m ^ (m >> 1);
    return m[ADDR_W:0];
  endfunction

  // Write side: store a word in RAM then publish the advanced pointer,
  // never letting unread words exceed the RAM depth.
  task automatic write_word();
    logic [DATA_W-1:0] d;
    if (wr_cnt - pops < 8) begin
      d = DATA_W'($urandom);
      ram[wr_cnt % 8] = d;
      exp_q.push_back(d);
      wr_cnt++;
      synch_write_ptr = to_gray(wr_cnt);
    end
  endtask

  // One clock: sample pre-edge activity at the falling edge, then update the
  // model and check registered outputs 1 time unit after the rising edge.
  task automatic cycle();
    logic             p_rst, p_issue, p_pop, p_valid, p_ready;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_dout;
    int               p_wr, lvl, n;
    #4;
    p_rst   = rst;
    p_issue = mem_rd_en;
    p_addr  = mem_rd_addr;
    p_valid = rd_if.dout_valid;
    p_ready = rd_if.dout_ready;
    p_pop   = p_valid & p_ready;
    p_dout  = rd_if.dout;
    p_wr    = wr_cnt;
    @(posedge clk);
    #1;
    if (p_rst) begin
      issues = 0; pops = 0; uf_m = 0; uf_cnt_m = 0; prev_gray = '0;
      check_val("rst_dout_valid", rd_if.dout_valid, 0);
      check_val("rst_rd_level", rd_level, 0);
      check_val("rst_gray", read_ptr_gray, 0);
      check_val("rst_almost_empty", almost_empty, 1);
    end else begin
      if (p_issue) begin
        check_val("rd_addr", p_addr, issues % 8);
        issues++;
      end
      if (p_pop) begin
        n = exp_q.size();
        check_val("pop_has_data", n != 0, 1);
        if (n != 0) check_val("dout_data", p_dout, exp_q.pop_front());
        pops++;
      end
      lvl = p_wr - pops;
      check_val("rd_level", rd_level, lvl);
      check_val("almost_empty", almost_empty, lvl <= AE_THRESH);
      check_val("empty", empty, !rd_if.dout_valid);
      check_val("read_ptr_gray", read_ptr_gray, to_gray(issues));
      check_val("gray_step", $countones(prev_gray ^ read_ptr_gray) <= 1, 1);
      prev_gray = read_ptr_gray;
      check_val("outstanding", (issues - pops) <= 2, 1);
      if (p_valid && !p_ready) begin
        check_val("hold_valid", rd_if.dout_valid, 1);
        check_val("hold_data", rd_if.dout, p_dout);
      end
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
      if (p_ready && !p_valid) begin
        uf_m = 1;
        if (uf_cnt_m < 255) uf_cnt_m++;
      end
      check_val("underflow", underflow, uf_m);
      check_val("underflow_cnt", underflow_cnt, uf_cnt_m);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_cnt = 0;
    synch_write_ptr = '0;
    exp_q.delete();
    rd_if.dout_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int base, target;
    rst = 1'b1;
    synch_write_ptr = '0;
    rd_if.dout_ready = 1'b0;
    wr_cnt = 0; issues = 0; pops = 0; prev_gray = '0; uf_m = 0; uf_cnt_m = 0;

    // Reset state
    do_reset();
    check_val("rst_mem_rd_en", mem_rd_en, 0);
    check_val("rst_dout", rd_if.dout, 0);
    check_val("rst_empty", empty, 1);
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
    check_val("rst_underflow", underflow, 0);
`endif

    // Single word with consumer stalled: issue at t, valid at t+2
    write_word();
    #1;
    check_val("single_issue", mem_rd_en, 1);
    check_val("single_addr", mem_rd_addr, 0);
    cycle();
    check_val("single_lat_t1", rd_if.dout_valid, 0);
    check_val("single_no_reissue", mem_rd_en, 0);
    cycle();
    check_val("single_lat_t2", rd_if.dout_valid, 1);
    check_val("single_gray", read_ptr_gray, 4'b0001);
    repeat (4) cycle();
    rd_if.dout_ready = 1'b1;
    cycle();
    check_val("single_drained", empty, 1);
    rd_if.dout_ready = 1'b0;

    // Streaming 8 words (RAM full at start) with dout_ready high
    do_reset();
    repeat (8) write_word();
    rd_if.dout_ready = 1'b1;
    cycle();
    check_val("stream_lat", rd_if.dout_valid, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_val("stream_valid", rd_if.dout_valid, 1);
    end
    cycle();
    check_val("stream_end", rd_if.dout_valid, 0);
    check_val("stream_gray_end", read_ptr_gray, 4'b1100);
    check_val("stream_level_end", rd_level, 0);

    // Backpressure: 5 words, only 2 reads before stall
    rd_if.dout_ready = 1'b0;
    base = issues;
    repeat (5) write_word();
    repeat (6) cycle();
    check_val("bp_issued", issues - base, 2);
    check_val("bp_valid", rd_if.dout_valid, 1);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      rd_if.dout_ready = (i % 2 == 0);
      cycle();
    end
    rd_if.dout_ready = 1'b0;
    check_val("bp_drained", exp_q.size(), 0);

    // Wrap: 20 words with random write and consume pacing
    target = wr_cnt + 20;
    for (int i = 0; i < 400 && (wr_cnt < target || exp_q.size() > 0); i++) begin
      if (wr_cnt < target && $urandom_range(0, 3) != 0) write_word();
      rd_if.dout_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check_val("wrap_written", wr_cnt, target);
    check_val("wrap_drained", exp_q.size(), 0);

    // Random soak with bursty writes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) write_word();
      rd_if.dout_ready = $urandom_range(0, 1);
      cycle();
    end

    // Reset in the cycle after an issue: returning data must be dropped
    do_reset();
    repeat (3) write_word();
    cycle();
    rst = 1'b1;
    #1;
    check_val("rst_blocks_issue", mem_rd_en, 0);
    wr_cnt = 0;
    synch_write_ptr = '0;
    exp_q.delete();
    cycle();
    rst = 1'b0;
    cycle();
    check_val("midrst_no_capture", rd_if.dout_valid, 0);
    check_val("midrst_gray", read_ptr_gray, 0);
    repeat (2) cycle();
    check_val("midrst_still_empty", rd_if.dout_valid, 0);
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
    rd_if.dout_ready = 1'b1;
    cycle();
    check_val("uf_set", underflow, 1);
    check_val("uf_cnt_one", underflow_cnt, 1);
    rd_if.dout_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
